// File: rtl/csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter_bank
// Brief    : mcycle / minstret / mhpmcounterN counter CSRs with mcountinhibit,
//            single-outstanding request/response CSR port.
// Revision : 1.0
// ============================================================================
module csr_counter_bank #(
    parameter int XLEN     = 32,
    parameter int NUM_HPM  = 4,
    parameter int RETIRE_W = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     csr_valid,
    output logic                                     csr_ready,
    input  logic [11:0]                              csr_addr,
    input  logic [1:0]                               csr_op,
    input  logic                                     csr_write_en,
    input  logic [XLEN-1:0]                          csr_wdata,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [XLEN-1:0]                          rsp_rdata,
    output logic                                     rsp_illegal,
    input  logic [RETIRE_W-1:0]                      instret_inc,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event
);

    // Counter slots: 0 = mcycle, 1 = minstret, 2+i = mhpmcounter(3+i)
    localparam int NCNT = 2 + NUM_HPM;

    localparam logic [31:0] c_inh_mask  = 32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
    localparam logic [0:0]  c_st_idle   = 1'b0;
    localparam logic [0:0]  c_st_resp   = 1'b1;

    logic [0:0]      r_state;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_illegal;
    logic [31:0]     r_inhibit;
    logic [63:0]     r_cnt [NCNT];

    logic [6:0]      w_base;
    logic [4:0]      w_off;
    logic            w_is_inh;
    logic            w_in_space;
    logic            w_hi;
    logic            w_user;
    logic            w_off_ok;
    logic [5:0]      w_idx;
    logic            w_legal;
    logic            w_accept;
    logic            w_do_wr;
    logic            w_wr_inh;
    logic            w_wr_cnt;
    logic [63:0]     w_old64;
    logic [XLEN-1:0] w_rd;
    logic [XLEN-1:0] w_field;
    logic [63:0]     w_new64;
    logic [63:0]     w_inc [NCNT];
    logic [NCNT-1:0] w_run;

    assign csr_ready   = (r_state == c_st_idle);
    assign rsp_valid   = (r_state == c_st_resp);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_illegal = r_rsp_illegal;

    // Address decode: 32-entry windows at B00, B80, C00, C80 share the same offset map
    always_comb begin
        w_base     = csr_addr[11:5];
        w_off      = csr_addr[4:0];
        w_is_inh   = (csr_addr == 12'h320);
        w_in_space = (w_base == 7'h58) || (w_base == 7'h5C) ||
                     (w_base == 7'h60) || (w_base == 7'h64);
        w_hi       = (w_base == 7'h5C) || (w_base == 7'h64);
        w_user     = (w_base == 7'h60) || (w_base == 7'h64);
        w_idx      = 6'd0;
        w_off_ok   = 1'b0;
        if (w_off == 5'd0) begin
            w_idx    = 6'd0;
            w_off_ok = 1'b1;
        end else if (w_off == 5'd2) begin
            w_idx    = 6'd1;
            w_off_ok = 1'b1;
        end else if ((w_off >= 5'd3) && ((int'(w_off) - 3) < NUM_HPM)) begin
            w_idx    = {1'b0, w_off} - 6'd1;
            w_off_ok = 1'b1;
        end
        w_legal = w_is_inh ||
                  (w_in_space && w_off_ok &&
                   !(w_hi && (XLEN == 64)) &&
                   !(w_user && csr_write_en));
    end

    assign w_accept = csr_valid && (r_state == c_st_idle);
    assign w_do_wr  = w_accept && w_legal && csr_write_en && (csr_op != 2'b00);
    assign w_wr_inh = w_do_wr && w_is_inh;
    assign w_wr_cnt = w_do_wr && !w_is_inh;

    always_comb begin
        w_old64 = 64'd0;
        for (int k = 0; k < NCNT; k++) begin
            if (w_idx == 6'(k)) begin
                w_old64 = r_cnt[k];
            end
        end
    end

    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_rd    = w_is_inh ? {32'd0, r_inhibit} : w_old64;
            assign w_new64 = w_field;
        end else begin : g_xlen32
            assign w_rd    = w_is_inh ? r_inhibit : (w_hi ? w_old64[63:32] : w_old64[31:0]);
            // Only the addressed half changes; the other half holds without carry
            assign w_new64 = w_hi ? {w_field, w_old64[31:0]} : {w_old64[63:32], w_field};
        end
    endgenerate

    always_comb begin
        case (csr_op)
            2'b01:   w_field = csr_wdata;
            2'b10:   w_field = w_rd | csr_wdata;
            2'b11:   w_field = w_rd & ~csr_wdata;
            default: w_field = w_rd;
        endcase
    end

    always_comb begin
        for (int k = 0; k < NCNT; k++) begin
            w_inc[k] = 64'd0;
        end
        w_run    = '0;
        w_inc[0] = 64'd1;
        w_run[0] = !r_inhibit[0];
        w_inc[1] = 64'(instret_inc);
        w_run[1] = !r_inhibit[2];
        for (int i = 0; i < NUM_HPM; i++) begin
            w_inc[2+i] = 64'(hpm_event[i]);
            w_run[2+i] = !r_inhibit[3+i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_rsp_rdata   <= '0;
            r_rsp_illegal <= 1'b0;
            r_inhibit     <= 32'd0;
            for (int k = 0; k < NCNT; k++) begin
                r_cnt[k] <= 64'd0;
            end
        end else begin
            if (r_state == c_st_idle) begin
                if (w_accept) begin
                    r_state       <= c_st_resp;
                    r_rsp_rdata   <= w_legal ? w_rd : '0;
                    r_rsp_illegal <= !w_legal;
                end
            end else if (rsp_ready) begin
                r_state <= c_st_idle;
            end

            // A written counter takes the write value instead of this cycle's increment
            for (int k = 0; k < NCNT; k++) begin
                if (w_wr_cnt && (w_idx == 6'(k))) begin
                    r_cnt[k] <= w_new64;
                end else if (w_run[k]) begin
                    r_cnt[k] <= r_cnt[k] + w_inc[k];
                end
            end

            if (w_wr_inh) begin
                r_inhibit <= w_field[31:0] & c_inh_mask;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_counter_bank
// Brief    : directed + random CSR traffic checked against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_csr_counter_bank;

    localparam int XLEN     = 32;
    localparam int NUM_HPM  = 4;
    localparam int RETIRE_W = 2;
    localparam int NCNT     = 2 + NUM_HPM;

    logic                clk;
    logic                rst;
    logic                csr_valid;
    logic                csr_ready;
    logic [11:0]         csr_addr;
    logic [1:0]          csr_op;
    logic                csr_write_en;
    logic [XLEN-1:0]     csr_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_rdata;
    logic                rsp_illegal;
    logic [RETIRE_W-1:0] instret_inc;
    logic [NUM_HPM-1:0]  hpm_event;

    csr_counter_bank #(
        .XLEN     (XLEN),
        .NUM_HPM  (NUM_HPM),
        .RETIRE_W (RETIRE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_valid    (csr_valid),
        .csr_ready    (csr_ready),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_write_en (csr_write_en),
        .csr_wdata    (csr_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_illegal  (rsp_illegal),
        .instret_inc  (instret_inc),
        .hpm_event    (hpm_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_cnt [NCNT];
    logic [31:0] m_inh  = 32'd0;
    bit          m_busy = 1'b0;
    logic [31:0] m_rd   = 32'd0;
    bit          m_ill  = 1'b0;

    function automatic int inh_bit(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : k + 1;
    endfunction

    function automatic logic [31:0] inh_mask();
        logic [31:0] m;
        m    = 32'd0;
        m[0] = 1'b1;
        m[2] = 1'b1;
        for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
        return m;
    endfunction

    // kind: 0 illegal, 1 counter (slot k, half hi), 2 mcountinhibit
    function automatic void tb_decode(input logic [11:0] a, input logic we,
                                      output int kind, output int k, output bit hi);
        int  base;
        int  off;
        bit  user;
        kind = 0; k = 0; hi = 1'b0; base = -1; user = 1'b0;
        if (a == 12'h320) begin
            kind = 2;
            return;
        end
        if      (a >= 12'hB00 && a <= 12'hB1F) base = 'hB00;
        else if (a >= 12'hB80 && a <= 12'hB9F) base = 'hB80;
        else if (a >= 12'hC00 && a <= 12'hC1F) base = 'hC00;
        else if (a >= 12'hC80 && a <= 12'hC9F) base = 'hC80;
        if (base < 0) return;
        off  = int'(a) - base;
        hi   = (base == 'hB80) || (base == 'hC80);
        user = (base >= 'hC00);
        if (off == 0)                           k = 0;
        else if (off == 2)                      k = 1;
        else if (off >= 3 && off < 3 + NUM_HPM) k = off - 1;
        else return;
        if (user && we) return;
        kind = 1;
    endfunction

    always @(posedge clk) begin
        int          kind, k, wk;
        bit          hi, inh_wr;
        logic [31:0] oldv, newv, inh_new;
        logic [63:0] wval, inc;
        if (rst) begin
            for (int j = 0; j < NCNT; j++) m_cnt[j] = 64'd0;
            m_inh = 32'd0; m_busy = 1'b0; m_rd = 32'd0; m_ill = 1'b0;
        end else begin
            wk = -1; inh_wr = 1'b0; wval = 64'd0; inh_new = 32'd0;
            if (csr_valid && !m_busy) begin
                tb_decode(csr_addr, csr_write_en, kind, k, hi);
                if (kind == 2)      oldv = m_inh;
                else if (kind == 1) oldv = hi ? m_cnt[k][63:32] : m_cnt[k][31:0];
                else                oldv = 32'd0;
                m_rd = oldv; m_ill = (kind == 0); m_busy = 1'b1;
                if (kind != 0 && csr_write_en && csr_op != 2'b00) begin
                    if (csr_op == 2'b01)      newv = csr_wdata;
                    else if (csr_op == 2'b10) newv = oldv | csr_wdata;
                    else                      newv = oldv & ~csr_wdata;
                    if (kind == 2) begin
                        inh_wr = 1'b1; inh_new = newv;
                    end else begin
                        wk = k; wval = m_cnt[k];
                        if (hi) wval[63:32] = newv; else wval[31:0] = newv;
                    end
                end
            end else if (m_busy && rsp_ready) begin
                m_busy = 1'b0;
            end
            for (int j = 0; j < NCNT; j++) begin
                inc = (j == 0) ? 64'd1 : (j == 1) ? 64'(instret_inc) : 64'(hpm_event[j-2]);
                if (j == wk) m_cnt[j] = wval;
                else if (!m_inh[inh_bit(j)]) m_cnt[j] = m_cnt[j] + inc;
            end
            if (inh_wr) m_inh = inh_new & inh_mask();
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("csr_ready", csr_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy);
            if (m_busy) begin
                chk("rsp_rdata", rsp_rdata, m_rd);
                chk("rsp_illegal", rsp_illegal, m_ill);
            end
        end
    end

    // ---------------- event stimulus ----------------
    bit                  rand_en  = 1'b1;
    logic [RETIRE_W-1:0] fix_inc  = '0;
    logic [NUM_HPM-1:0]  fix_hpm  = '0;
    always @(negedge clk) begin
        #2;
        if (rand_en) begin
            instret_inc = RETIRE_W'($urandom);
            hpm_event   = NUM_HPM'($urandom);
        end else begin
            instret_inc = fix_inc;
            hpm_event   = fix_hpm;
        end
    end

    task automatic req(input logic [11:0] a, input logic [1:0] op, input logic we,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic ill);
        int t;
        @(negedge clk);
        csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_write_en = we; csr_wdata = wd;
        rsp_ready = (hold == 0);
        t = 0;
        while (!csr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!csr_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        csr_valid = 1'b0;
        rd  = rsp_rdata;
        ill = rsp_illegal;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rdata", rsp_rdata, rd);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_ready", csr_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    logic [11:0] addr_tab [16] = '{12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hB05, 12'hB06,
                                   12'hB07, 12'hB01, 12'hB80, 12'hB82, 12'hB86, 12'hC00,
                                   12'hC03, 12'hC80, 12'h320, 12'h7C0};

    initial begin
        logic [31:0] a, b, c, d, rd;
        logic        ill;
        rst = 1'b1; csr_valid = 1'b0; csr_addr = 12'h0; csr_op = 2'b00;
        csr_write_en = 1'b0; csr_wdata = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_csr_ready", csr_ready, 1'b1);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_illegal", rsp_illegal, 1'b0);

        // Ten idle cycles after reset release, then read mcycle
        repeat (9) @(negedge clk);
        req(12'hB00, 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("mcycle_after_reset", rd, 32'd10);
        chk("mcycle_legal", ill, 1'b0);

        // Low-half carry into high half
        req(12'hB00, 2'b01, 1'b1, 32'hFFFF_FFFF, 0, rd, ill);
        req(12'hB80, 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("mcycleh_carry", rd, 32'd1);

        // Inhibit mcycle, confirm frozen, release
        req(12'h320, 2'b10, 1'b1, 32'd1, 0, rd, ill);
        req(12'hB00, 2'b00, 1'b0, 32'd0, 0, a, ill);
        repeat (5) @(negedge clk);
        req(12'hB00, 2'b00, 1'b0, 32'd0, 0, b, ill);
        chk("inhibit_frozen", b, a);
        req(12'h320, 2'b11, 1'b1, 32'd1, 0, rd, ill);
        req(12'hB00, 2'b00, 1'b0, 32'd0, 0, c, ill);
        chk("inhibit_resume", c > b, 1'b1);

        // Illegal accesses
        req(12'hC00, 2'b01, 1'b1, 32'd5, 0, rd, ill);
        chk("user_write_illegal", ill, 1'b1);
        chk("user_write_rdata", rd, 32'd0);
        req(12'hB83 + 12'(NUM_HPM), 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("hpm_oob_illegal", ill, 1'b1);
        req(12'hC02, 2'b10, 1'b0, 32'd0, 0, rd, ill);
        chk("user_read_legal", ill, 1'b0);

        // Held response and exact instret/hpm accumulation
        rand_en = 1'b0; fix_inc = '0; fix_hpm = '0;
        @(negedge clk);
        req(12'hB02, 2'b00, 1'b0, 32'd0, 4, a, ill);
        fix_inc = 2'd2;
        repeat (3) @(negedge clk);
        fix_inc = 2'd0;
        req(12'hB02, 2'b00, 1'b0, 32'd0, 0, b, ill);
        chk("minstret_plus6", b - a, 32'd6);
        req(12'hB03, 2'b00, 1'b0, 32'd0, 0, a, ill);
        req(12'hB04, 2'b00, 1'b0, 32'd0, 0, c, ill);
        fix_hpm = 4'b0101;
        repeat (2) @(negedge clk);
        fix_hpm = '0;
        req(12'hB03, 2'b00, 1'b0, 32'd0, 0, b, ill);
        req(12'hB04, 2'b00, 1'b0, 32'd0, 0, d, ill);
        chk("hpm3_plus2", b - a, 32'd2);
        chk("hpm4_idle", d - c, 32'd0);

        // Reset while a response is pending
        req(12'h320, 2'b01, 1'b1, 32'h0000_0004, 0, rd, ill);
        @(negedge clk);
        csr_valid = 1'b1; csr_addr = 12'hB00; csr_op = 2'b00; csr_write_en = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        csr_valid = 1'b0;
        chk("pre_rst_valid", rsp_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_drops_rsp", rsp_valid, 1'b0);
        chk("rst_ready", csr_ready, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_stale_rsp", rsp_valid, 1'b0);
        end
        rsp_ready = 1'b1;
        req(12'hB02, 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("minstret_cleared", rd, 32'd0);
        req(12'hB03, 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("hpm3_cleared", rd, 32'd0);
        req(12'h320, 2'b00, 1'b0, 32'd0, 0, rd, ill);
        chk("inhibit_cleared", rd, 32'd0);

        // Random traffic against the model
        rand_en = 1'b1;
        repeat (80) begin
            req(addr_tab[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), $urandom, $urandom_range(0, 3), rd, ill);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_counter_bank.md
CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32, CSR data width; legal values 32 or 64.
REQ-002 SHALL have parameter NUM_HPM, default 4, number of hpmcounters (3..3+NUM_HPM-1); legal 0..29.
REQ-003 SHALL have parameter RETIRE_W, default 2, width of instret_inc.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port csr_valid  input  1  CSR request present.
REQ-007 SHALL have port csr_ready  output  1  bank can accept a request.
REQ-008 SHALL have port csr_addr  input  12  CSR address (csr_t encoding).
REQ-009 SHALL have port csr_op  input  2  01=RW, 10=RS, 11=RC (csr_op_t); 00 treated as read-only.
REQ-010 SHALL have port csr_write_en  input  1  request performs a write (0 for RS/RC with x0 source).
REQ-011 SHALL have port csr_wdata  input  XLEN  write/set/clear operand.
REQ-012 SHALL have port rsp_valid  output  1  response held.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  output  XLEN  old CSR value.
REQ-015 SHALL have port rsp_illegal  output  1  request raised ILLEGAL_INST.
REQ-016 SHALL have port instret_inc  input  RETIRE_W  instructions retired this cycle.
REQ-017 SHALL have port hpm_event  input  max(NUM_HPM,1)  per-counter increment strobe.

Function
REQ-018 SHALL hold 64-bit counters mcycle, minstret, hpm[0..NUM_HPM-1] and register mcountinhibit (bit0 CY, bit2 IR, bit 3+i HPMi; others read 0, ignore writes).
REQ-019 SHALL implement FSM IDLE/RESP: IDLE csr_ready=1; csr_valid&&csr_ready -> RESP; RESP csr_ready=0, rsp_valid=1; rsp_ready in RESP -> IDLE; back-to-back accept in the cycle after RESP exits.
REQ-020 SHALL decode: MCYCLE B00, MINSTRET B02, MHPMCOUNTER B03+i, high halves B80/B82/B83+i, MCOUNTINHIBIT 320, user shadows C00/C02/C03+i and C80/C82/C83+i.
REQ-021 SHALL flag illegal for: unmapped address, i>=NUM_HPM, any high-half address when XLEN=64, user shadow with csr_write_en=1.
REQ-022 SHALL latch rsp_rdata as the addressed value at the accept edge (before write/increment); XLEN=32 low/high halves = bits 31:0/63:32; XLEN=64 full counter; illegal -> rsp_rdata=0.
REQ-023 SHALL apply write at accept edge only if legal and csr_write_en: RW new=wdata, RS old|wdata, RC old&~wdata, on the addressed half only.
REQ-024 SHALL increment each cycle when not inhibited: mcycle +1, minstret +instret_inc (zero-extended), hpm[i] +hpm_event[i]; wrap 2^64-1 -> 0 silently.
REQ-025 SHALL give write priority: a counter written this cycle takes the write value and skips that cycle's increment; the other half of that counter holds (no carry); other counters increment normally.
REQ-026 SHALL apply a write to mcountinhibit from the following cycle onward (increment in the write cycle uses old inhibit).
REQ-027 SHALL propagate low-half carry into high half in the same cycle (XLEN=32 reads of high half see a consistent 64-bit value).
REQ-028 SHALL keep rsp_rdata/rsp_illegal stable while rsp_valid=1 and rsp_ready=0; counters keep counting.

Reset
REQ-029 SHALL on rst=1 clear all counters, mcountinhibit, rsp_valid, rsp_rdata, rsp_illegal; csr_ready=1 the cycle after; FSM -> IDLE.
REQ-030 SHALL on rst during RESP drop the pending response with no later rsp_valid; rst overrides any same-cycle write.

Verification
REQ-031 SHALL cover: reset, 10 idle cycles, read B00 -> rsp_rdata=10 (cycles since reset release, pre-increment), rsp_illegal=0.
REQ-032 SHALL cover: XLEN=32, write B00=FFFF_FFFF (RW), next cycle read B80 -> 1 (carry into high half).
REQ-033 SHALL cover: RS 320 with wdata=1, then read B00 twice 5 cycles apart -> equal values; RC 320 wdata=1 resumes counting.
REQ-034 SHALL cover: write C00 with csr_write_en=1 -> rsp_illegal=1, rsp_rdata=0, mcycle unchanged besides increment; read B83+NUM_HPM -> illegal.
REQ-035 SHALL cover: rsp_ready held 0 for 4 cycles -> rsp_valid, rsp_rdata stable, csr_ready=0; instret_inc=2 for 3 cycles -> minstret +6.
REQ-036 SHALL cover: rst asserted in RESP -> rsp_valid=0 next cycle, counters 0, no stale response after release.
